// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer and its users.
package pc_sequencer_pkg;

    // Default widths, shared with instruction memory and top-level instantiation
    localparam int unsigned PC_W_DEF  = 10;
    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned OFF_W     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer_pc_next.sv
// Combinational next-address calculator: pc+1 or pc+sign_extend(offset), modulo 2^PC_W.
module pc_next
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned PC_W = PC_W_DEF
) (
    input  logic [PC_W-1:0]  pc,
    input  logic             jump_flag,
    input  logic [OFF_W-1:0] jump_offset,
    output logic [PC_W-1:0]  next_pc
);

    logic [PC_W-1:0] offset_ext;

    // Sign-extend the branch offset and add; the adder width gives the wrap for free
    always_comb begin
        offset_ext = {{(PC_W - OFF_W){jump_offset[OFF_W-1]}}, jump_offset};
        next_pc    = pc + (jump_flag ? offset_ext : PC_W'(1));
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter, run/halt FSM and saturating retired-instruction counter.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned PC_W  = PC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt,
    input  logic             stall,
    input  logic             jump_flag,
    input  logic [OFF_W-1:0] jump_offset,
    output logic [PC_W-1:0]  pc,
    output logic             running,
    output logic             done,
    output logic [CNT_W-1:0] instr_count
);

    seq_state_t       state;
    seq_state_t       state_next;
    logic [PC_W-1:0]  pc_d;
    logic [PC_W-1:0]  pc_step;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    pc_next #(
        .PC_W(PC_W)
    ) u_pc_next (
        .pc          (pc),
        .jump_flag   (jump_flag),
        .jump_offset (jump_offset),
        .next_pc     (pc_step)
    );

    assign cnt_inc = (&instr_count) ? instr_count : instr_count + CNT_W'(1);
    assign running = (state == RUN);
    assign done    = (state == DONE);

    // State, PC and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= '0;
            instr_count <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_d;
            instr_count <= cnt_d;
        end
    end

    // Next-state, next-PC and next-count selection
    always_comb begin
        state_next = state;
        pc_d       = pc;
        cnt_d      = instr_count;
        unique case (state)
            IDLE: begin
                pc_d  = '0;
                cnt_d = '0;
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!stall) begin
                    cnt_d = cnt_inc;
                    if (halt) begin
                        state_next = DONE;
                    end else begin
                        pc_d = pc_step;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_next = RUN;
                    pc_d       = '0;
                    cnt_d      = '0;
                end
            end
            default: begin
                state_next = IDLE;
                pc_d       = '0;
                cnt_d      = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed plan plus randomized traffic against a behavioural model.
module tb_pc_sequencer;

    localparam int PC_W   = 10;
    localparam int CNT_W  = 6;
    localparam int PC_MOD = 1 << PC_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             halt = 1'b0;
    logic             stall = 1'b0;
    logic             jump_flag = 1'b0;
    logic [7:0]       jump_offset = '0;
    logic [PC_W-1:0]  pc;
    logic             running;
    logic             done;
    logic [CNT_W-1:0] instr_count;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Model: mode 0 = idle, 1 = executing, 2 = finished
    int m_mode = 0;
    int m_pc = 0;
    int m_cnt = 0;

    pc_sequencer #(
        .PC_W  (PC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .halt        (halt),
        .stall       (stall),
        .jump_flag   (jump_flag),
        .jump_offset (jump_offset),
        .pc          (pc),
        .running     (running),
        .done        (done),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model advanced on each rising edge from the applied inputs
    always @(posedge clk) begin
        int off;
        if (reset) begin
            m_mode = 0; m_pc = 0; m_cnt = 0;
        end else if (m_mode == 1) begin
            if (!stall) begin
                if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
                if (halt) begin
                    m_mode = 2;
                end else if (jump_flag) begin
                    off = int'(jump_offset);
                    if (off >= 128) off = off - 256;
                    m_pc = (m_pc + off + PC_MOD) % PC_MOD;
                end else begin
                    m_pc = (m_pc + 1) % PC_MOD;
                end
            end
        end else if (start) begin
            m_mode = 1; m_pc = 0; m_cnt = 0;
        end
    end

    // Compare every cycle once the DUT has been reset
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc", int'(pc), m_pc);
            chk("running", int'(running), int'(m_mode == 1));
            chk("done", int'(done), int'(m_mode == 2));
            chk("instr_count", int'(instr_count), m_cnt);
        end
    end

    // Apply inputs at a falling edge and return at the following falling edge
    task automatic step(input bit r, input bit s, input bit h, input bit st,
                        input bit jf, input logic [7:0] off);
        reset = r; start = s; halt = h; stall = st; jump_flag = jf; jump_offset = off;
        @(negedge clk);
    endtask

    task automatic plain(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 8'h00);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        step(1, 0, 0, 0, 0, 8'h00);
        chk_en = 1'b1;
        chk("reset_pc", int'(pc), 0);
        chk("reset_running", int'(running), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_count", int'(instr_count), 0);

        // Plan 1: start then five sequential fetches
        step(0, 1, 0, 0, 0, 8'h00);
        chk("start_pc", int'(pc), 0);
        chk("start_running", int'(running), 1);
        plain(5);
        chk("seq_pc", int'(pc), 5);
        chk("seq_count", int'(instr_count), 5);
        chk("model_seq_pc", m_pc, 5);

        // Plan 2: backward then maximum forward branch
        plain(5);
        chk("pc10", int'(pc), 10);
        step(0, 0, 0, 0, 1, 8'hFD);
        chk("jump_back_pc", int'(pc), 7);
        step(0, 0, 0, 0, 1, 8'h7F);
        chk("jump_fwd_pc", int'(pc), 134);
        chk("model_jump_fwd_pc", m_pc, 134);

        // Plan 3: stall with a pending jump
        step(0, 0, 0, 0, 1, 8'h8E);
        chk("pc20", int'(pc), 20);
        chk("count13", int'(instr_count), 13);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 8'h55);
        chk("stall_pc", int'(pc), 20);
        chk("stall_count", int'(instr_count), 13);
        step(0, 0, 0, 0, 1, 8'h04);
        chk("after_stall_pc", int'(pc), 24);

        // Plan 4: halt together with jump, hold in done, restart
        step(1, 0, 0, 0, 0, 8'h00);
        step(0, 1, 0, 0, 0, 8'h00);
        plain(10);
        step(0, 0, 0, 0, 1, 8'h00);
        step(0, 0, 0, 0, 1, 8'd20);
        chk("pc30", int'(pc), 30);
        chk("count12", int'(instr_count), 12);
        step(0, 0, 1, 0, 1, 8'h10);
        chk("halt_pc", int'(pc), 30);
        chk("halt_count", int'(instr_count), 13);
        chk("halt_done", int'(done), 1);
        chk("halt_running", int'(running), 0);
        step(0, 0, 1, 1, 1, 8'h33);
        step(0, 0, 0, 0, 1, 8'h02);
        chk("done_hold_pc", int'(pc), 30);
        chk("done_hold_count", int'(instr_count), 13);
        step(0, 1, 0, 0, 0, 8'h00);
        chk("restart_pc", int'(pc), 0);
        chk("restart_count", int'(instr_count), 0);
        chk("restart_running", int'(running), 1);

        // Plan 5: wrap at top and below zero
        step(0, 0, 0, 0, 1, 8'hFF);
        chk("pc1023", int'(pc), 1023);
        plain(1);
        chk("wrap_top_pc", int'(pc), 0);
        plain(2);
        step(0, 0, 0, 0, 1, 8'h80);
        chk("wrap_neg_pc", int'(pc), 898);

        // Plan 6: start ignored in run, reset mid-run
        step(1, 0, 0, 0, 0, 8'h00);
        step(0, 1, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 1, 8'd49);
        step(0, 1, 0, 0, 0, 8'h00);
        chk("start_in_run_pc", int'(pc), 50);
        step(1, 1, 1, 0, 1, 8'h05);
        chk("midrun_reset_pc", int'(pc), 0);
        chk("midrun_reset_running", int'(running), 0);
        chk("midrun_reset_done", int'(done), 0);
        chk("midrun_reset_count", int'(instr_count), 0);

        // Counter saturation
        step(0, 1, 0, 0, 0, 8'h00);
        plain(CNT_MAX + 10);
        chk("sat_count", int'(instr_count), CNT_MAX);
        chk("sat_pc", int'(pc), CNT_MAX + 10);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 47) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 1) == 1),
                 8'($urandom()));
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter and fetch sequencer. It sits directly downstream of the ALU: it consumes the ALU's branch decision (jumpFlag) and its 8-bit result (the branch offset) and produces the next instruction address for instruction memory. It also owns the run/halt control, the start/done handshake with the testbench or top level, and a retired-instruction counter.

Parameters:
- PC_W, 10, width of the program counter and instruction-memory address.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high; forces IDLE.
- start  input  1  level; begins execution from address 0 when in IDLE or DONE.
- halt  input  1  from decode; the current instruction is a halt.
- stall  input  1  from control; freezes the PC and the counter this cycle.
- jump_flag  input  1  ALU jumpFlag for the current instruction.
- jump_offset  input  8  ALU out; signed two's-complement PC-relative offset.
- pc  output  PC_W  address of the current instruction.
- running  output  1  high in RUN.
- done  output  1  high in DONE.
- instr_count  output  CNT_W  number of instructions retired since the last start.

Behaviour:
- One clock domain. Reset is synchronous and active-high. All state updates happen on the rising edge of clk.
- Reset values: state=IDLE, pc=0, instr_count=0, running=0, done=0. Reset wins over every other input, including mid-RUN.
- running and done are decoded directly from the state register: they are valid in the same cycle as the state, with no extra latency.
- The FSM has three states: IDLE, RUN and DONE.

IDLE:
- pc is held at 0.
- start=1 -> next state RUN, pc=0, instr_count=0.

RUN:
- Each edge with stall=0 retires the current instruction and increments instr_count.
- Next PC is selected in this priority order:
  1. stall=1: pc and instr_count hold. halt and jump_flag are ignored; decode must hold them until the stall clears.
  2. halt=1: next state DONE, pc holds. The halt instruction is counted. jump_flag is ignored.
  3. jump_flag=1: pc <= pc + sign_extend(jump_offset).
  4. Otherwise: pc <= pc + 1.
- All PC arithmetic is modulo 2^PC_W. Incrementing at the top address wraps to 0. Negative offsets below 0 wrap to the top of the address space. Neither case raises an error.
- jump_offset is sign-extended from bit 7 to PC_W bits. Its range is -128..+127. An offset of 0 is a legal self-loop.
- instr_count saturates at 2^CNT_W-1 and does not wrap.
- start is ignored while in RUN.

DONE:
- pc and instr_count hold their final values. done=1.
- start=1 -> RUN, pc=0, instr_count=0 (restart).
- halt, stall and jump_flag are ignored.

Combinational inputs:
- jump_flag and jump_offset are sampled only in RUN with stall=0. The block has no combinational path from inputs to pc.

Decomposition:
- Shared definitions package:
  - a typedef enum for IDLE, RUN and DONE (a 2-bit state type);
  - the PC_W and CNT_W defaults as package constants, so that instruction memory and top-level instantiation use the same widths.
- One natural sub-module, pc_next: a purely combinational next-address calculator. Inputs: pc, jump_flag, jump_offset. Output: the incremented or branch address with sign extension and wrap.
- The FSM, the PC register and the counter stay in pc_sequencer.

Test Plan:
1. Reset, then start for 1 cycle, then 5 cycles with no jumps -> pc sequence 0,1,2,3,4,5; running=1; instr_count=5.
2. At pc=10, drive jump_flag=1 with jump_offset=8'hFD (-3) -> pc=7 next cycle. Then jump_offset=8'h7F with jump_flag=1 -> pc=134.
3. Hold stall=1 for 3 cycles at pc=20 while jump_flag=1 -> pc stays 20 and instr_count is unchanged. After stall drops with jump_offset=4 -> pc=24.
4. halt=1 and jump_flag=1 together at pc=30, instr_count=12 -> DONE, pc=30, instr_count=13, done=1. Further cycles hold. start=1 -> RUN, pc=0, count=0.
5. Wrap cases:
   - pc=1023 with no jump -> pc=0.
   - pc=2 with jump_offset=8'h80 -> pc=898.
6. Reset asserted mid-RUN at pc=50 -> next cycle IDLE, pc=0, running=0, done=0, instr_count=0. start in RUN (without reset) has no effect on pc.
